// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: default widths and the encoding
// of the two-bit operand-pair index used by coverage logic.
package arith_pkg;

  localparam int unsigned HA_CNT_W = 8;

  localparam logic [1:0] IDX_00 = 2'd0;
  localparam logic [1:0] IDX_01 = 2'd1;
  localparam logic [1:0] IDX_10 = 2'd2;
  localparam logic [1:0] IDX_11 = 2'd3;

  // Operand pair {a,b} as an index, a is the more significant bit.
  function automatic logic [1:0] pair_idx(input logic a, input logic b);
    return {a, b};
  endfunction

  // One-hot mask selecting the coverage bit for a given pair index.
  function automatic logic [3:0] idx_mask(input logic [1:0] idx);
    logic [3:0] m;
    m = 4'b0000;
    case (idx)
      IDX_00:  m = 4'b0001;
      IDX_01:  m = 4'b0010;
      IDX_10:  m = 4'b0100;
      IDX_11:  m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/half_adder_core.sv
// Purely combinational one-bit half adder, shared with the full adders.
// X/Z on the operands propagates to the outputs unmasked.
module half_adder_core (
  input  logic A,
  input  logic B,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B;
  assign Cout = A & B;

endmodule

// File: rtl/half_adder_1b.sv
// One-bit half adder with a registered observation stage: registered
// result, saturating carry-event counter and operand-pair coverage mask.
// The combinational outputs bypass reset entirely.
module half_adder_1b
  import arith_pkg::*;
#(
  parameter int unsigned CNT_W = HA_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  output logic             S,
  output logic             Cout,
  output logic             S_r,
  output logic             Cout_r,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [3:0]       seen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s_comb;
  logic             cout_comb;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       seen_next;

  half_adder_core u_core (
    .A    (A),
    .B    (B),
    .S    (s_comb),
    .Cout (cout_comb)
  );

  assign S    = s_comb;
  assign Cout = cout_comb;

  // Next counter value: count carries, pinned at all-ones.
  always_comb begin
    cnt_next = carry_cnt;
    if (cout_comb && (carry_cnt != CNT_MAX)) begin
      cnt_next = carry_cnt + CNT_ONE;
    end
  end

  // Next coverage mask: sticky OR of the currently presented pair.
  always_comb begin
    seen_next = seen | idx_mask(pair_idx(A, B));
  end

  // Registered copy of the sum and carry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      S_r    <= 1'b0;
      Cout_r <= 1'b0;
    end else begin
      S_r    <= s_comb;
      Cout_r <= cout_comb;
    end
  end

  // Saturating carry-event counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_cnt <= '0;
    end else begin
      carry_cnt <= cnt_next;
    end
  end

  // Operand-pair coverage mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen <= 4'b0000;
    end else begin
      seen <= seen_next;
    end
  end

endmodule

// File: tb/tb_half_adder_1b.sv
// Self-checking bench for half_adder_1b: an 8-bit and a 2-bit counter
// instance share the operand and reset drives. Expected registered
// responses are queued per instance and checked by a monitor process.
module tb_half_adder_1b;

  logic       clock;
  logic       reset;
  logic       A, B;

  logic       s8, c8, sr8, cr8;
  logic [7:0] cnt8;
  logic [3:0] seen8;

  logic       s2, c2, sr2, cr2;
  logic [1:0] cnt2;
  logic [3:0] seen2;

  typedef struct {
    int       s_r;
    int       cout_r;
    int       cnt;
    bit [3:0] seen;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt8, m_cnt2;
  bit m_seen[4];

  half_adder_1b dut8 (
    .clock(clock), .reset(reset), .A(A), .B(B),
    .S(s8), .Cout(c8), .S_r(sr8), .Cout_r(cr8),
    .carry_cnt(cnt8), .seen(seen8)
  );

  half_adder_1b #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .A(A), .B(B),
    .S(s2), .Cout(c2), .S_r(sr2), .Cout_r(cr2),
    .carry_cnt(cnt2), .seen(seen2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit [3:0] seen_vec();
    bit [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_seen[k];
    return v;
  endfunction

  task automatic model_clear();
    m_cnt8 = 0;
    m_cnt2 = 0;
    for (int k = 0; k < 4; k++) m_seen[k] = 1'b0;
  endtask

  task automatic chk_comb(input string tag);
    int sum;
    sum = int'(A) + int'(B);
    chk({tag, "_S8"},    {31'd0, s8}, sum % 2);
    chk({tag, "_Cout8"}, {31'd0, c8}, sum / 2);
    chk({tag, "_S2"},    {31'd0, s2}, sum % 2);
    chk({tag, "_Cout2"}, {31'd0, c2}, sum / 2);
  endtask

  // Present one operand pair for one clock edge.
  task automatic cycle(input bit a, input bit b);
    int sum;
    exp_t e;
    @(negedge clock);
    A = a;
    B = b;
    #1;
    chk_comb("comb");
    sum = int'(a) + int'(b);
    m_seen[a * 2 + b] = 1'b1;
    if (sum >= 2) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
    e.s_r = sum % 2; e.cout_r = sum / 2; e.seen = seen_vec();
    e.cnt = m_cnt8; q8.push_back(e);
    e.cnt = m_cnt2; q2.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_Sr8"},   {31'd0, sr8}, 0);
    chk({tag, "_Cr8"},   {31'd0, cr8}, 0);
    chk({tag, "_cnt8"},  {24'd0, cnt8}, 0);
    chk({tag, "_seen8"}, {28'd0, seen8}, 0);
    chk({tag, "_Sr2"},   {31'd0, sr2}, 0);
    chk({tag, "_Cr2"},   {31'd0, cr2}, 0);
    chk({tag, "_cnt2"},  {30'd0, cnt2}, 0);
    chk({tag, "_seen2"}, {28'd0, seen2}, 0);
  endtask

  // Assert reset between edges, verify immediate clear and hold, release.
  task automatic async_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst_now");
    chk_comb("rst_comb");
    A = ~A;
    #1;
    chk_comb("rst_comb_tog");
    model_clear();
    chk("rst_q8_empty", q8.size(), 0);
    chk("rst_q2_empty", q2.size(), 0);
    q8.delete();
    q2.delete();
    @(posedge clock);
    #1;
    chk_zero("rst_hold");
    #2;
    reset = 1'b0;
  endtask

  // Monitor: each sampling edge out of reset consumes one expected response.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("mon_Sr8",   {31'd0, sr8},   e.s_r);
        chk("mon_Cr8",   {31'd0, cr8},   e.cout_r);
        chk("mon_cnt8",  {24'd0, cnt8},  e.cnt);
        chk("mon_seen8", {28'd0, seen8}, {28'd0, e.seen});
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("mon_Sr2",   {31'd0, sr2},   e.s_r);
        chk("mon_Cr2",   {31'd0, cr2},   e.cout_r);
        chk("mon_cnt2",  {30'd0, cnt2},  e.cnt);
        chk("mon_seen2", {28'd0, seen2}, {28'd0, e.seen});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int sat_tab[5];
    sat_tab = '{1, 2, 3, 3, 3};
    A = 1'b0;
    B = 1'b0;
    reset = 1'b0;
    model_clear();
    #2;
    reset = 1'b1;
    #1;
    chk_zero("init_rst");
    @(posedge clock);
    #3;
    reset = 1'b0;

    // Exhaustive sweep
    cycle(0, 0); cycle(0, 1); cycle(1, 0); cycle(1, 1);
    @(posedge clock);
    #2;
    chk("sweep_seen8", {28'd0, seen8}, 32'hF);
    chk("sweep_cnt8",  {24'd0, cnt8},  1);

    // Registered path
    cycle(1, 1);
    @(posedge clock);
    #2;
    chk("reg11_Sr", {31'd0, sr8}, 0);
    chk("reg11_Cr", {31'd0, cr8}, 1);
    cycle(0, 0);
    @(posedge clock);
    #2;
    chk("reg00_Sr", {31'd0, sr8}, 0);
    chk("reg00_Cr", {31'd0, cr8}, 0);

    // Saturation on the 2-bit instance
    async_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1);
      @(posedge clock);
      #2;
      chk("sat_cnt2", {30'd0, cnt2}, sat_tab[i]);
    end
    cycle(0, 0); cycle(0, 1); cycle(1, 0);
    @(posedge clock);
    #2;
    chk("pre_rst_cnt2",  {30'd0, cnt2},  3);
    chk("pre_rst_seen2", {28'd0, seen2}, 32'hF);

    // Mid-operation reset and release with A=1, B=0
    async_reset();
    cycle(1, 0);
    @(posedge clock);
    #2;
    chk("rel_Sr",   {31'd0, sr8},   1);
    chk("rel_Cr",   {31'd0, cr8},   0);
    chk("rel_seen", {28'd0, seen8}, 32'h4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(posedge clock);
    @(posedge clock);
    #2;
    chk("end_q8_empty", q8.size(), 0);
    chk("end_q2_empty", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder_1b.md
# half_adder_1b

One-bit half adder with a small registered observation stage. The core is combinational: it sums two single-bit operands into a sum bit and a carry bit. The wrapper adds a registered copy of the result, a saturating carry-event counter and an input-combination coverage mask, all clocked and asynchronously reset. It sits at the leaf level of the arithmetic library and is the building block for ripple adders.

## Interface

- CNT_W, default 8 – width of the carry-event counter (≥2).
- clock  input  1  – single system clock; all state updates on its rising edge.
- reset  input  1  – asynchronous, active-high reset of all registered state.
- A  input  1  – operand bit A.
- B  input  1  – operand bit B.
- S  output  1  – combinational sum, A XOR B.
- Cout  output  1  – combinational carry, A AND B.
- S_r  output  1  – S registered on the rising clock edge.
- Cout_r  output  1  – Cout registered on the rising clock edge.
- carry_cnt  output  CNT_W  – number of rising edges at which Cout was 1, saturating.
- seen  output  4  – bit k set once the input pair {A,B}==k has been sampled at a rising edge.

## Operation

- S = A ^ B and Cout = A & B, purely combinational. They are valid whenever the inputs are stable and are independent of clock and reset.
- Arithmetic identity: {Cout,S} equals A + B as a 2-bit unsigned value (0+0=00, 0+1=01, 1+0=01, 1+1=10).
- S_r and Cout_r load S and Cout on every rising edge when reset is low.
- carry_cnt increments by 1 on each rising edge where Cout==1. It holds at 2^CNT_W−1 and never wraps.
- seen[{A,B}] is set on each rising edge (index = 2·A + B). Bits are sticky until reset. seen==4'b1111 indicates exhaustive coverage.
- Reset (asynchronous, active-high) forces S_r=0, Cout_r=0, carry_cnt=0 and seen=0 immediately, regardless of clock. These values are held while reset is high.
- Reset has no effect on S and Cout.
- X or Z on A or B propagates to S and Cout. No masking is performed.

## Timing

- S and Cout: zero-cycle (combinational) latency. They must settle within the same half clock period in which inputs change, because consumers sample them at the next rising edge.
- S_r and Cout_r: one-cycle latency. They reflect the inputs present at the previous rising edge.
- carry_cnt and seen update one cycle after the sampled edge, with the same latency as S_r and Cout_r.
- Reset deassertion: registers begin updating at the first rising edge after reset falls. There is no synchronizer inside the block; the reset source guarantees release timing.
- Reset mid-operation clears the counter and mask immediately. Combinational outputs continue to track inputs.
- Saturation boundary: at carry_cnt = 2^CNT_W−2 with Cout=1, the next value is 2^CNT_W−1, and it stays there on further carries.

## Structure

- Shared package arith_pkg:
  - default counter width constant HA_CNT_W = 8;
  - localparam encoding of the input-pair index (IDX_00=0, IDX_01=1, IDX_10=2, IDX_11=3).
- Sub-module half_adder_core: purely combinational A,B → S,Cout. It is reused by full adders elsewhere.
- The top module half_adder_1b instantiates half_adder_core and contains the output registers, the saturating counter and the coverage mask.

## Test plan

- Exhaustive combinational check: apply {A,B} = 00, 01, 10, 11, each held for 10 time units against a 10-unit clock, sampled at each rising edge. Required {Cout,S} = 00, 01, 01, 10, i.e. 0+0=0, 0+1=1, 1+0=1, 1+1=2.
- Registered path: apply 11 then 00 on consecutive cycles. Required: S_r/Cout_r = 0/1 one cycle after 11, then 0/0 one cycle later.
- Coverage and counter: after the exhaustive sweep, required seen=4'b1111 and carry_cnt=1.
- Saturation: with CNT_W=2, hold A=B=1 for 5 cycles. Required carry_cnt sequence 1, 2, 3, 3, 3.
- Asynchronous reset: assert reset between clock edges with carry_cnt=3 and seen=4'b1111. Required: carry_cnt=0, seen=0, S_r=Cout_r=0 immediately, while S/Cout still track A/B.
- Reset release: deassert reset with A=1, B=0. Required: after the first rising edge, S_r=1, Cout_r=0 and seen=4'b0100.
